// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the data-memory port of the dmem
//   arbiter into one interface.
//   Port 0 carries mips load/store traffic. Port 1 carries DMA/debug-loader traffic.
//   Signals:
//     m0_req/m0_we/m0_addr/m0_wdata : port 0 request (held until m0_gnt)
//     m0_gnt/m0_rvalid/m0_rdata     : port 0 accept / read-return
//     m1_*                          : same set for port 1
//     mem_we/mem_addr/mem_wdata     : dmem command
//     mem_rdata                     : dmem read data
//   Modports:
//     slave  - the arbiter's view
//     master - the requesters plus dmem (the surrounding system)
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single dmem port between two requesters.
//   Port 0 has fixed priority. Port 1 wins once it has lost MAX_WAIT
//   consecutive contended arbitrations.
//   Writes complete in the grant cycle. Read data returns RD_LAT cycles later
//   as a one-cycle rvalid pulse on the owning port.
//   m0_gnt low acts as the CPU stall.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous, active-low reset
//     bus   - dmem_arbiter_if slave modport (both requesters + dmem)
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            own, own_next;
    logic            pend, pend_next;
    logic [WW-1:0]   wait_cnt, wait_next;
    logic            grant_ok, sel0, sel1, sel_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            own      <= 1'b0;
            pend     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            own      <= own_next;
            pend     <= pend_next;
            wait_cnt <= wait_next;
        end
    end

    // pend marks the cycle in which the outstanding read's data is on
    // mem_rdata. That cycle is always IDLE, so a fresh grant may overlap it.
    // own is only overwritten at the next clock edge, so the rvalid pulse
    // still goes to the previous owner.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        own_next      = own;
        pend_next     = 1'b0;
        wait_next     = wait_cnt;
        sel0          = 1'b0;
        sel1          = 1'b0;
        sel_we        = 1'b0;
        bus.m0_gnt    = 1'b0;
        bus.m1_gnt    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        // Gating with reset keeps the combinational grants low while reset is held.
        grant_ok = reset && (state == IDLE);

        if (grant_ok) begin
            if (bus.m0_req && !(bus.m1_req && wait_cnt == WW'(MAX_WAIT)))
                sel0 = 1'b1;
            else if (bus.m1_req)
                sel1 = 1'b1;
        end

        if (sel0) begin
            bus.m0_gnt    = 1'b1;
            bus.mem_we    = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
            sel_we        = bus.m0_we;
            own_next      = 1'b0;
            if (bus.m1_req && wait_cnt != WW'(MAX_WAIT))
                wait_next = wait_cnt + WW'(1);
        end else if (sel1) begin
            bus.m1_gnt    = 1'b1;
            bus.mem_we    = bus.m1_we;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
            sel_we        = bus.m1_we;
            own_next      = 1'b1;
            wait_next     = '0;
        end

        if ((sel0 || sel1) && !sel_we) begin
            if (RD_LAT == 1) begin
                pend_next = 1'b1;
            end else begin
                state_next = RD_WAIT;
                cnt_next   = CW'(RD_LAT - 1);
            end
        end

        // The last wait cycle hands back to IDLE. Data is then valid in the next cycle.
        if (state == RD_WAIT) begin
            if (cnt == CW'(1)) begin
                state_next = IDLE;
                pend_next  = 1'b1;
            end else begin
                cnt_next = cnt - CW'(1);
            end
        end
    end

    always_comb begin
        bus.m0_rvalid = pend && !own;
        bus.m1_rvalid = pend && own;
        bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
        bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Testbench for dmem_arbiter.
//   Two instances are used: u_dut1 with RD_LAT=1 and u_dut3 with RD_LAT=3
//   (both MAX_WAIT=4). Each has a small behavioural dmem behind it.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled on
//   the falling edge.
module tb_dmem_arbiter;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_WAIT(4)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_WAIT(4)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmem models: 16 words indexed by addr[5:2], read-before-write,
    // read data delayed by the instance's RD_LAT.
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] rd1;
    logic [31:0] p0, p1, p2;

    always @(posedge clk) begin
        if (bus1.mem_we) mem1[bus1.mem_addr[5:2]] <= bus1.mem_wdata;
        rd1 <= mem1[bus1.mem_addr[5:2]];
        if (bus3.mem_we) mem3[bus3.mem_addr[5:2]] <= bus3.mem_wdata;
        p0 <= mem3[bus3.mem_addr[5:2]];
        p1 <= p0;
        p2 <= p1;
    end

    assign bus1.mem_rdata = rd1;
    assign bus3.mem_rdata = p2;

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mwe;
        logic [31:0] maddr, mwdata;
        logic        v0;
        logic [31:0] rd0;
        logic        v1;
        logic [31:0] rdt1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus1.m0_req   = v.r0;
        bus1.m0_we    = v.w0;
        bus1.m0_addr  = v.a0;
        bus1.m0_wdata = v.d0;
        bus1.m1_req   = v.r1;
        bus1.m1_we    = v.w1;
        bus1.m1_addr  = v.a1;
        bus1.m1_wdata = v.d1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("row%0d", idx);
        chk({tag, ".m0_gnt"},    32'(bus1.m0_gnt),    32'(v.g0));
        chk({tag, ".m1_gnt"},    32'(bus1.m1_gnt),    32'(v.g1));
        chk({tag, ".mem_we"},    32'(bus1.mem_we),    32'(v.mwe));
        chk({tag, ".mem_addr"},  bus1.mem_addr,       v.maddr);
        chk({tag, ".mem_wdata"}, bus1.mem_wdata,      v.mwdata);
        chk({tag, ".m0_rvalid"}, 32'(bus1.m0_rvalid), 32'(v.v0));
        chk({tag, ".m0_rdata"},  bus1.m0_rdata,       v.rd0);
        chk({tag, ".m1_rvalid"}, 32'(bus1.m1_rvalid), 32'(v.v1));
        chk({tag, ".m1_rdata"},  bus1.m1_rdata,       v.rdt1);
    endtask

    task automatic clearBus3();
        bus3.m0_req = L; bus3.m0_we = L; bus3.m0_addr = Z; bus3.m0_wdata = Z;
        bus3.m1_req = L; bus3.m1_we = L; bus3.m1_addr = Z; bus3.m1_wdata = Z;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset held low with a port-0 write pending.
        reset = 1'b0;
        clearBus3();
        bus1.m1_req = L; bus1.m1_we = L; bus1.m1_addr = Z; bus1.m1_wdata = Z;
        bus1.m0_req = H; bus1.m0_we = H; bus1.m0_addr = 32'h40; bus1.m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rst.m0_gnt", 32'(bus1.m0_gnt), 0);
        chk("rst.mem_we", 32'(bus1.mem_we), 0);
        chk("rst.mem_addr", bus1.mem_addr, Z);
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rel.m0_gnt", 32'(bus1.m0_gnt), 1);
        chk("rel.mem_we", 32'(bus1.mem_we), 1);
        chk("rel.mem_addr", bus1.mem_addr, 32'h40);
        chk("rel.mem_wdata", bus1.mem_wdata, 32'hDEADBEEF);
        nextCycle();

        // Table for RD_LAT=1: reads, writes, alternating read stream, fairness.
        vecs.push_back('{H,L,32'h40,Z, L,L,Z,Z, H,L,L,32'h40,Z, L,Z,L,Z});
        vecs.push_back('{L,L,Z,Z, L,L,Z,Z, L,L,L,Z,Z, H,32'hDEADBEEF,L,Z});
        vecs.push_back('{L,L,Z,Z, H,H,32'h44,32'h11112222, L,H,H,32'h44,32'h11112222, L,Z,L,Z});
        vecs.push_back('{H,H,32'h48,32'h33334444, L,L,Z,Z, H,L,H,32'h48,32'h33334444, L,Z,L,Z});
        vecs.push_back('{H,L,32'h44,Z, L,L,Z,Z, H,L,L,32'h44,Z, L,Z,L,Z});
        vecs.push_back('{L,L,Z,Z, H,L,32'h48,Z, L,H,L,32'h48,Z, H,32'h11112222,L,Z});
        vecs.push_back('{H,L,32'h40,Z, L,L,Z,Z, H,L,L,32'h40,Z, L,Z,H,32'h33334444});
        vecs.push_back('{L,L,Z,Z, H,L,32'h44,Z, L,H,L,32'h44,Z, H,32'hDEADBEEF,L,Z});
        vecs.push_back('{L,L,Z,Z, L,L,Z,Z, L,L,L,Z,Z, L,Z,H,32'h11112222});
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4)
                vecs.push_back('{H,H,32'h50,32'hA0A0A0A0, H,H,32'h54,32'hB1B1B1B1,
                                 L,H,H,32'h54,32'hB1B1B1B1, L,Z,L,Z});
            else
                vecs.push_back('{H,H,32'h50,32'hA0A0A0A0, H,H,32'h54,32'hB1B1B1B1,
                                 H,L,H,32'h50,32'hA0A0A0A0, L,Z,L,Z});
        end
        vecs.push_back('{H,L,32'h40,Z, H,L,32'h48,Z, H,L,L,32'h40,Z, L,Z,L,Z});
        vecs.push_back('{L,L,Z,Z, H,L,32'h48,Z, L,H,L,32'h48,Z, H,32'hDEADBEEF,L,Z});
        vecs.push_back('{L,L,Z,Z, L,L,Z,Z, L,L,L,Z,Z, L,Z,H,32'h33334444});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(i, vecs[i]);
            nextCycle();
        end

        // RD_LAT=3: a port-1 read blocks port 0 until the data-return cycle.
        bus3.m0_req = H; bus3.m0_we = H; bus3.m0_addr = 32'h48; bus3.m0_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("lat3.wr.m0_gnt", 32'(bus3.m0_gnt), 1);
        chk("lat3.wr.mem_we", 32'(bus3.mem_we), 1);
        nextCycle();
        clearBus3();
        bus3.m1_req = H; bus3.m1_addr = 32'h48;
        @(negedge clk);
        chk("lat3.T.m1_gnt", 32'(bus3.m1_gnt), 1);
        chk("lat3.T.mem_addr", bus3.mem_addr, 32'h48);
        nextCycle();
        clearBus3();
        bus3.m0_req = H; bus3.m0_we = H; bus3.m0_addr = 32'h4C; bus3.m0_wdata = 32'h55555555;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("lat3.T%0d.m0_gnt", c), 32'(bus3.m0_gnt), 0);
            chk($sformatf("lat3.T%0d.mem_addr", c), bus3.mem_addr, Z);
            chk($sformatf("lat3.T%0d.m1_rvalid", c), 32'(bus3.m1_rvalid), 0);
            nextCycle();
        end
        @(negedge clk);
        chk("lat3.T3.m0_gnt", 32'(bus3.m0_gnt), 1);
        chk("lat3.T3.mem_we", 32'(bus3.mem_we), 1);
        chk("lat3.T3.m1_rvalid", 32'(bus3.m1_rvalid), 1);
        chk("lat3.T3.m1_rdata", bus3.m1_rdata, 32'hCAFEF00D);
        chk("lat3.T3.m0_rvalid", 32'(bus3.m0_rvalid), 0);
        nextCycle();
        clearBus3();
        @(negedge clk);
        chk("lat3.T4.m1_rvalid", 32'(bus3.m1_rvalid), 0);
        nextCycle();

        // Reset during an outstanding read drops it and clears the wait counter.
        bus3.m0_req = H; bus3.m0_addr = 32'h4C;
        bus3.m1_req = H; bus3.m1_addr = 32'h48;
        @(negedge clk);
        chk("rstrd.m0_gnt", 32'(bus3.m0_gnt), 1);
        chk("rstrd.m1_gnt", 32'(bus3.m1_gnt), 0);
        nextCycle();
        clearBus3();
        reset = 1'b0;
        @(negedge clk);
        chk("rstrd.low.m0_gnt", 32'(bus3.m0_gnt), 0);
        chk("rstrd.low.mem_addr", bus3.mem_addr, Z);
        nextCycle();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rstrd.c%0d.m0_rvalid", c), 32'(bus3.m0_rvalid), 0);
            chk($sformatf("rstrd.c%0d.m1_rvalid", c), 32'(bus3.m1_rvalid), 0);
            nextCycle();
        end
        chk("rstrd.wait_cnt", 32'(u_dut3.wait_cnt), 0);
        bus3.m0_req = H; bus3.m0_addr = 32'h40;
        @(negedge clk);
        chk("rstrd.idle.m0_gnt", 32'(bus3.m0_gnt), 1);
        nextCycle();
        clearBus3();
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
